// File: rtl/ti_share_stage_reg.sv
// ti_share_stage_reg: registered share boundary between two TI S-box layers.
// The block takes a 3-share triple and can remask it with fresh randomness.
// It holds up to two triples in a skid FIFO.
// The head entry drives the outputs straight from flops, so downstream
// coordinate functions never see glitches that originate upstream.
module ti_share_stage_reg #(
    parameter int W       = 4,
    parameter bit REFRESH = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_s0,
    input  logic [W-1:0]   in_s1,
    input  logic [W-1:0]   in_s2,
    input  logic [2*W-1:0] rnd,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_s0,
    output logic [W-1:0]   out_s1,
    output logic [W-1:0]   out_s2,
    output logic [1:0]     occ
);

    typedef struct packed {
        logic [W-1:0] s0;
        logic [W-1:0] s1;
        logic [W-1:0] s2;
    } triple_t;

    triple_t    mem [2];
    triple_t    wr_t;
    logic       hd;
    logic [1:0] cnt;
    logic       push, pop, wr_idx;
    logic [W-1:0] r0, r1;

    assign r0 = rnd[W-1:0];
    assign r1 = rnd[2*W-1:W];

    // Remask each share independently; shares are never combined with each other.
    always_comb begin
        wr_t = '{s0: in_s0, s1: in_s1, s2: in_s2};
        if (REFRESH) begin
            wr_t.s0 = in_s0 ^ r0;
            wr_t.s1 = in_s1 ^ r1;
            wr_t.s2 = in_s2 ^ r0 ^ r1;
        end
    end

    // Ready depends only on the registered count; it is held low while rst is high.
    assign in_ready  = ~rst & ~cnt[1];
    assign out_valid = (cnt != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    // The new entry goes at the head when the FIFO is empty, otherwise in the slot behind the head.
    assign wr_idx    = hd ^ (cnt == 2'd1);

    // Storage, head pointer and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            hd  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (push) mem[wr_idx] <= wr_t;
            if (pop)  hd <= ~hd;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // The head flops feed the outputs directly and act as the glitch barrier.
    assign out_s0 = mem[hd].s0;
    assign out_s1 = mem[hd].s1;
    assign out_s2 = mem[hd].s2;
    assign occ    = cnt;

endmodule

// File: tb/tb_ti_share_stage_reg.sv
// Bench for ti_share_stage_reg.
// It drives a REFRESH=1 instance and a REFRESH=0 instance from the same inputs.
// A queue-based reference model computes the expected outputs.
module tb_ti_share_stage_reg;
    logic clk, rst, in_valid, out_ready;
    logic [3:0] in_s0, in_s1, in_s2;
    logic [7:0] rnd;
    logic       ir_r, ov_r, ir_p, ov_p;
    logic [3:0] o0_r, o1_r, o2_r, o0_p, o1_p, o2_p;
    logic [1:0] occ_r, occ_p;

    int nchk = 0, nerr = 0;
    logic [11:0] qr[$], qp[$];
    int maxocc;

    ti_share_stage_reg #(.W(4), .REFRESH(1'b1)) u_r (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_r),
        .in_s0(in_s0), .in_s1(in_s1), .in_s2(in_s2), .rnd(rnd),
        .out_valid(ov_r), .out_ready(out_ready),
        .out_s0(o0_r), .out_s1(o1_r), .out_s2(o2_r), .occ(occ_r));

    ti_share_stage_reg #(.W(4), .REFRESH(1'b0)) u_p (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_p),
        .in_s0(in_s0), .in_s1(in_s1), .in_s2(in_s2), .rnd(rnd),
        .out_valid(ov_p), .out_ready(out_ready),
        .out_s0(o0_p), .out_s1(o1_p), .out_s2(o2_p), .occ(occ_p));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running, need done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, need %0h", nm, act, exp);
        end
    endtask

    // One clock: predict the effect of the edge, advance, then compare every output.
    task automatic step();
        bit acc, pp, stall;
        logic [11:0] tr, tp, prev_r, prev_p;
        logic [3:0] r0, r1;
        r0 = rnd[3:0];
        r1 = rnd[7:4];
        acc = in_valid && !rst && qr.size() < 2;
        pp  = out_ready && !rst && qr.size() > 0;
        tr  = {in_s0 ^ r0, in_s1 ^ r1, in_s2 ^ r0 ^ r1};
        tp  = {in_s0, in_s1, in_s2};
        stall  = !rst && qr.size() > 0 && !out_ready;
        prev_r = {o0_r, o1_r, o2_r};
        prev_p = {o0_p, o1_p, o2_p};
        @(posedge clk);
        #1;
        if (rst) begin
            qr.delete();
            qp.delete();
        end else begin
            if (pp) begin void'(qr.pop_front()); void'(qp.pop_front()); end
            if (acc) begin qr.push_back(tr); qp.push_back(tp); end
        end
        if (qr.size() > maxocc) maxocc = qr.size();
        chk("occ_r", occ_r, qr.size());
        chk("occ_p", occ_p, qp.size());
        chk("out_valid_r", ov_r, qr.size() != 0);
        chk("out_valid_p", ov_p, qp.size() != 0);
        chk("in_ready_r", ir_r, !rst && qr.size() < 2);
        chk("in_ready_p", ir_p, !rst && qp.size() < 2);
        if (qr.size() > 0) chk("head_r", {o0_r, o1_r, o2_r}, qr[0]);
        if (qp.size() > 0) chk("head_p", {o0_p, o1_p, o2_p}, qp[0]);
        if (stall && !rst) begin
            chk("stall_hold_r", {o0_r, o1_r, o2_r}, prev_r);
            chk("stall_hold_p", {o0_p, o1_p, o2_p}, prev_p);
        end
    endtask

    typedef struct {
        logic [3:0] s0, s1, s2;
        logic [7:0] rnd;
        logic [3:0] e0, e1, e2;  // expected REFRESH=1 shares
    } vec_t;
    vec_t vt[4];

    initial begin
        vt[0] = '{s0: 4'h3, s1: 4'h5, s2: 4'h9, rnd: 8'hA6, e0: 4'h5, e1: 4'hF, e2: 4'h5};
        vt[1] = '{s0: 4'h0, s1: 4'h0, s2: 4'h0, rnd: 8'hFF, e0: 4'hF, e1: 4'hF, e2: 4'h0};
        vt[2] = '{s0: 4'h1, s1: 4'h2, s2: 4'h4, rnd: 8'h00, e0: 4'h1, e1: 4'h2, e2: 4'h4};
        vt[3] = '{s0: 4'hC, s1: 4'h7, s2: 4'hE, rnd: 8'h3B, e0: 4'h7, e1: 4'h4, e2: 4'h6};
        maxocc = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_s0 = '0; in_s1 = '0; in_s2 = '0; rnd = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", ir_r, 0);
        chk("rst_occ", occ_r, 0);
        chk("rst_out_valid", ov_r, 0);
        chk("rst_outs", {o0_r, o1_r, o2_r, o0_p, o1_p, o2_p}, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", ir_r, 1);

        // Table: single push/pop with known remask results
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            in_s0 = vt[i].s0; in_s1 = vt[i].s1; in_s2 = vt[i].s2; rnd = vt[i].rnd;
            step();
            chk($sformatf("vec%0d_valid", i), ov_r, 1);
            chk($sformatf("vec%0d_refresh", i), {o0_r, o1_r, o2_r}, {vt[i].e0, vt[i].e1, vt[i].e2});
            chk($sformatf("vec%0d_plain", i), {o0_p, o1_p, o2_p}, {vt[i].s0, vt[i].s1, vt[i].s2});
            chk($sformatf("vec%0d_xor", i), o0_r ^ o1_r ^ o2_r, vt[i].s0 ^ vt[i].s1 ^ vt[i].s2);
            in_valid = 1'b0;
            step();
            chk($sformatf("vec%0d_drain", i), ov_r, 0);
        end

        // Backpressure: A, B held, extra push refused, then in-order release
        out_ready = 1'b0; in_valid = 1'b1;
        in_s0 = 4'h1; in_s1 = 4'h2; in_s2 = 4'h3; rnd = 8'h00;
        step();
        in_s0 = 4'h4; in_s1 = 4'h5; in_s2 = 4'h6;
        step();
        chk("bp_occ2", occ_p, 2);
        chk("bp_in_ready", ir_p, 0);
        chk("bp_head_A", {o0_p, o1_p, o2_p}, 12'h123);
        in_s0 = 4'h7; in_s1 = 4'h8; in_s2 = 4'h9;
        step();
        chk("bp_hold_A", {o0_p, o1_p, o2_p}, 12'h123);
        chk("bp_no_push", occ_p, 2);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("bp_head_B", {o0_p, o1_p, o2_p}, 12'h456);
        chk("bp_ready_back", ir_p, 1);
        step();
        chk("bp_empty", ov_p, 0);

        // Streaming: 16 back-to-back triples
        maxocc = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_s0 = 4'($urandom); in_s1 = 4'($urandom); in_s2 = 4'($urandom); rnd = 8'($urandom);
            step();
            chk("stream_xor", o0_r ^ o1_r ^ o2_r, qp[0][11:8] ^ qp[0][7:4] ^ qp[0][3:0]);
        end
        in_valid = 1'b0;
        step();
        chk("stream_maxocc", maxocc, 1);

        // Random stall traffic
        for (int i = 0; i < 1000; i++) begin
            in_valid = 1'($urandom); out_ready = 1'($urandom);
            in_s0 = 4'($urandom); in_s1 = 4'($urandom); in_s2 = 4'($urandom); rnd = 8'($urandom);
            step();
            if (qr.size() > 0)
                chk("rand_xor", o0_r ^ o1_r ^ o2_r, qp[0][11:8] ^ qp[0][7:4] ^ qp[0][3:0]);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        chk("rand_drained", occ_r, 0);

        // Reset while full
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (2) step();
        chk("mr_full", occ_r, 2);
        rst = 1'b1; out_ready = 1'b1;
        #1;
        chk("mr_in_ready_low", ir_r, 0);
        step();
        chk("mr_occ", occ_r, 0);
        chk("mr_out_valid", ov_r, 0);
        chk("mr_outs", {o0_r, o1_r, o2_r, o0_p, o1_p, o2_p}, 0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("mr_in_ready_back", ir_r, 1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
